// File: rtl/jelly2_rtos_event_capture_pkg.sv
// Shared constants for the event-capture front-end: register word addresses
// and the access type of each register.
package jelly2_rtos_event_capture_pkg;

    localparam int REG_NUM       = 8;

    localparam int ADR_ENABLE    = 0;
    localparam int ADR_EDGE_RISE = 1;
    localparam int ADR_EDGE_FALL = 2;
    localparam int ADR_DEBOUNCE  = 3;
    localparam int ADR_PENDING   = 4;
    localparam int ADR_OVERFLOW  = 5;
    localparam int ADR_LEVEL     = 6;
    localparam int ADR_SOFT_TRIG = 7;

    typedef enum logic [1:0] {
        ACC_RW  = 2'd0,
        ACC_W1C = 2'd1,
        ACC_RO  = 2'd2,
        ACC_WO  = 2'd3
    } acc_type_e;

    function automatic acc_type_e reg_access(input int adr);
        case (adr)
            ADR_PENDING,
            ADR_OVERFLOW:  return ACC_W1C;
            ADR_LEVEL:     return ACC_RO;
            ADR_SOFT_TRIG: return ACC_WO;
            default:       return ACC_RW;
        endcase
    endfunction

endpackage

// File: rtl/jelly2_rtos_event_capture_if.sv
// Single-cycle WISHBONE slave bus used by the event-capture register file.
interface jelly2_rtos_event_capture_if
    import jelly2_rtos_event_capture_pkg::*;
#(
    parameter int WB_ADR_WIDTH = $clog2(REG_NUM),
    parameter int WB_DAT_WIDTH = 32,
    parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8
);
    logic [WB_ADR_WIDTH-1:0] s_wb_adr_i;
    logic [WB_DAT_WIDTH-1:0] s_wb_dat_i;
    logic [WB_DAT_WIDTH-1:0] s_wb_dat_o;
    logic                    s_wb_we_i;
    logic [WB_SEL_WIDTH-1:0] s_wb_sel_i;
    logic                    s_wb_stb_i;
    logic                    s_wb_ack_o;

    modport master (
        output s_wb_adr_i,
        output s_wb_dat_i,
        output s_wb_we_i,
        output s_wb_sel_i,
        output s_wb_stb_i,
        input  s_wb_dat_o,
        input  s_wb_ack_o
    );

    modport slave (
        input  s_wb_adr_i,
        input  s_wb_dat_i,
        input  s_wb_we_i,
        input  s_wb_sel_i,
        input  s_wb_stb_i,
        output s_wb_dat_o,
        output s_wb_ack_o
    );

endinterface

// File: rtl/jelly2_rtos_event_capture_filter.sv
// One event line: multi-stage synchroniser followed by a debounce counter.
// level_o changes only after the synchronised input has disagreed with it for
// debounce_i+1 consecutive cycles; rise_o/fall_o pulse for the cycle after
// level_o changes.
module jelly2_rtos_event_capture_filter #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      din_i,
    input  logic [DEBOUNCE_WIDTH-1:0] debounce_i,
    output logic                      level_o,
    output logic                      rise_o,
    output logic                      fall_o
);

    logic [SYNC_STAGES-1:0]    sync_q, sync_d;
    logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
    logic                      level_q, level_d;
    logic                      rise_q, rise_d;
    logic                      fall_q, fall_d;
    logic                      sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Shift the synchroniser and run the debounce counter against the filtered level.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din_i};
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_out != level_q) begin
            if (cnt_q == debounce_i) begin
                level_d = sync_out;
                rise_d  = sync_out;
                fall_d  = ~sync_out;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/jelly2_rtos_event_capture.sv
// Event-capture front-end for one jelly2_rtos flag group: per-event filter,
// programmable edge detection, pending/overflow status and a WISHBONE
// register file. set_flg carries one-cycle pulses into ext_set_flg.
module jelly2_rtos_event_capture
    import jelly2_rtos_event_capture_pkg::*;
#(
    parameter int WB_ADR_WIDTH   = 3,
    parameter int WB_DAT_WIDTH   = 32,
    parameter int WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
    parameter int EVENT_NUM      = 8,
    parameter int FLGPTN_WIDTH   = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [EVENT_NUM-1:0]      event_in,
    output logic [FLGPTN_WIDTH-1:0]   set_flg,
    jelly2_rtos_event_capture_if.slave s_wb
);

    logic [EVENT_NUM-1:0]      enable_q, enable_d;
    logic [EVENT_NUM-1:0]      edge_rise_q, edge_rise_d;
    logic [EVENT_NUM-1:0]      edge_fall_q, edge_fall_d;
    logic [DEBOUNCE_WIDTH-1:0] debounce_q, debounce_d;
    logic [EVENT_NUM-1:0]      pending_q, pending_d;
    logic [EVENT_NUM-1:0]      overflow_q, overflow_d;
    logic [EVENT_NUM-1:0]      soft_q, soft_d;
    logic [EVENT_NUM-1:0]      set_flg_q, set_flg_d;

    logic [EVENT_NUM-1:0]      level, rise, fall, hit;
    logic [EVENT_NUM-1:0]      clr_pending, clr_overflow;
    logic [WB_DAT_WIDTH-1:0]   wmask, wr_data, rd_data;
    logic [FLGPTN_WIDTH-1:0]   set_flg_ext;
    logic                      wr_en;
    logic                      wr_enable, wr_edge_rise, wr_edge_fall, wr_debounce;
    logic                      wr_pending, wr_overflow, wr_soft;
    logic                      unused_wr;

    // Per-event synchroniser and debounce filters.
    for (genvar i = 0; i < EVENT_NUM; i++) begin : g_filter
        jelly2_rtos_event_capture_filter #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
        ) u_filter (
            .clk        (clk),
            .reset      (reset),
            .din_i      (event_in[i]),
            .debounce_i (debounce_q),
            .level_o    (level[i]),
            .rise_o     (rise[i]),
            .fall_o     (fall[i])
        );
    end

    // Expand byte-lane selects to a per-bit write mask.
    always_comb begin
        wmask = '0;
        for (int b = 0; b < WB_SEL_WIDTH; b++) begin
            wmask[b*8 +: 8] = {8{s_wb.s_wb_sel_i[b]}};
        end
    end

    assign wr_data   = s_wb.s_wb_dat_i & wmask;
    assign unused_wr = ^wr_data;
    assign wr_en     = s_wb.s_wb_stb_i & s_wb.s_wb_we_i;

    assign wr_enable    = wr_en && (s_wb.s_wb_adr_i == WB_ADR_WIDTH'(ADR_ENABLE));
    assign wr_edge_rise = wr_en && (s_wb.s_wb_adr_i == WB_ADR_WIDTH'(ADR_EDGE_RISE));
    assign wr_edge_fall = wr_en && (s_wb.s_wb_adr_i == WB_ADR_WIDTH'(ADR_EDGE_FALL));
    assign wr_debounce  = wr_en && (s_wb.s_wb_adr_i == WB_ADR_WIDTH'(ADR_DEBOUNCE));
    assign wr_pending   = wr_en && (s_wb.s_wb_adr_i == WB_ADR_WIDTH'(ADR_PENDING));
    assign wr_overflow  = wr_en && (s_wb.s_wb_adr_i == WB_ADR_WIDTH'(ADR_OVERFLOW));
    assign wr_soft      = wr_en && (s_wb.s_wb_adr_i == WB_ADR_WIDTH'(ADR_SOFT_TRIG));

    assign clr_pending  = wr_pending  ? wr_data[EVENT_NUM-1:0] : '0;
    assign clr_overflow = wr_overflow ? wr_data[EVENT_NUM-1:0] : '0;

    // Register writes, hit detection and pending/overflow update; a hit
    // overrides a simultaneous write-1-to-clear on the same bit.
    always_comb begin
        enable_d    = enable_q;
        edge_rise_d = edge_rise_q;
        edge_fall_d = edge_fall_q;
        debounce_d  = debounce_q;
        if (wr_enable) begin
            enable_d = (enable_q & ~wmask[EVENT_NUM-1:0]) | wr_data[EVENT_NUM-1:0];
        end
        if (wr_edge_rise) begin
            edge_rise_d = (edge_rise_q & ~wmask[EVENT_NUM-1:0]) | wr_data[EVENT_NUM-1:0];
        end
        if (wr_edge_fall) begin
            edge_fall_d = (edge_fall_q & ~wmask[EVENT_NUM-1:0]) | wr_data[EVENT_NUM-1:0];
        end
        if (wr_debounce) begin
            debounce_d = (debounce_q & ~wmask[DEBOUNCE_WIDTH-1:0]) | wr_data[DEBOUNCE_WIDTH-1:0];
        end
        soft_d     = wr_soft ? wr_data[EVENT_NUM-1:0] : '0;
        hit        = (enable_q & ((rise & edge_rise_q) | (fall & edge_fall_q))) | soft_q;
        set_flg_d  = hit;
        pending_d  = (pending_q & ~clr_pending) | hit;
        overflow_d = (overflow_q & ~clr_overflow) | (hit & pending_q);
    end

    // Register file and pulse output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q    <= '0;
            edge_rise_q <= '0;
            edge_fall_q <= '0;
            debounce_q  <= '0;
            pending_q   <= '0;
            overflow_q  <= '0;
            soft_q      <= '0;
            set_flg_q   <= '0;
        end else begin
            enable_q    <= enable_d;
            edge_rise_q <= edge_rise_d;
            edge_fall_q <= edge_fall_d;
            debounce_q  <= debounce_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            soft_q      <= soft_d;
            set_flg_q   <= set_flg_d;
        end
    end

    // Combinational read mux; bus reads as zero without a read strobe.
    always_comb begin
        rd_data = '0;
        if (s_wb.s_wb_stb_i && !s_wb.s_wb_we_i) begin
            case (s_wb.s_wb_adr_i)
                WB_ADR_WIDTH'(ADR_ENABLE):    rd_data[EVENT_NUM-1:0]      = enable_q;
                WB_ADR_WIDTH'(ADR_EDGE_RISE): rd_data[EVENT_NUM-1:0]      = edge_rise_q;
                WB_ADR_WIDTH'(ADR_EDGE_FALL): rd_data[EVENT_NUM-1:0]      = edge_fall_q;
                WB_ADR_WIDTH'(ADR_DEBOUNCE):  rd_data[DEBOUNCE_WIDTH-1:0] = debounce_q;
                WB_ADR_WIDTH'(ADR_PENDING):   rd_data[EVENT_NUM-1:0]      = pending_q;
                WB_ADR_WIDTH'(ADR_OVERFLOW):  rd_data[EVENT_NUM-1:0]      = overflow_q;
                WB_ADR_WIDTH'(ADR_LEVEL):     rd_data[EVENT_NUM-1:0]      = level;
                default:                      rd_data                     = '0;
            endcase
        end
    end

    // Zero-extend the event pulses onto the full flag pattern.
    always_comb begin
        set_flg_ext                = '0;
        set_flg_ext[EVENT_NUM-1:0] = set_flg_q;
    end

    assign set_flg         = set_flg_ext;
    assign s_wb.s_wb_dat_o = rd_data;
    assign s_wb.s_wb_ack_o = s_wb.s_wb_stb_i;

endmodule

// File: tb/tb_jelly2_rtos_event_capture.sv
// Bench for jelly2_rtos_event_capture: expected set_flg pulses (value and
// cycle) are queued when stimulus is applied and matched by a monitor.
module tb_jelly2_rtos_event_capture;
    import jelly2_rtos_event_capture_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  event_in;
    logic [31:0] set_flg;

    jelly2_rtos_event_capture_if wb_if ();

    jelly2_rtos_event_capture dut (
        .clk      (clk),
        .reset    (reset),
        .event_in (event_in),
        .set_flg  (set_flg),
        .s_wb     (wb_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pulse monitor: every nonzero set_flg must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (set_flg != 32'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", set_flg, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pulse_val", set_flg, mon_e.val);
                    chk("pulse_cyc", 32'(cyc), 32'(mon_e.cyc));
                end
            end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
                mon_e = sb.pop_front();
                chk("pulse_missing", set_flg, mon_e.val);
            end
        end
    end

    task automatic wb_write(input int adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_if.s_wb_adr_i = 3'(adr);
        wb_if.s_wb_dat_i = dat;
        wb_if.s_wb_sel_i = sel;
        wb_if.s_wb_we_i  = 1'b1;
        wb_if.s_wb_stb_i = 1'b1;
        #1 chk("ack_wr", 32'(wb_if.s_wb_ack_o), 32'd1);
        @(negedge clk);
        wb_if.s_wb_stb_i = 1'b0;
        wb_if.s_wb_we_i  = 1'b0;
        #1 chk("ack_idle", 32'(wb_if.s_wb_ack_o), 32'd0);
    endtask

    task automatic rd_chk(input string tag, input int adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_if.s_wb_adr_i = 3'(adr);
        wb_if.s_wb_we_i  = 1'b0;
        wb_if.s_wb_stb_i = 1'b1;
        #1;
        d = wb_if.s_wb_dat_o;
        chk("ack_rd", 32'(wb_if.s_wb_ack_o), 32'd1);
        chk(tag, d, exp);
        @(negedge clk);
        wb_if.s_wb_stb_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_type_e acc;
        reset            = 1'b1;
        event_in         = '0;
        wb_if.s_wb_adr_i = '0;
        wb_if.s_wb_dat_i = '0;
        wb_if.s_wb_sel_i = '0;
        wb_if.s_wb_we_i  = 1'b0;
        wb_if.s_wb_stb_i = 1'b0;
        idle(3);
        reset = 1'b0;
        #1;
        chk("rst_set_flg", set_flg, 32'd0);
        chk("rst_dat_o_idle", wb_if.s_wb_dat_o, 32'd0);
        mon_en = 1'b1;
        for (int a = 0; a < REG_NUM; a++) begin
            acc = reg_access(a);
            rd_chk($sformatf("rst_%s_%0d", acc.name(), a), a, 32'd0);
        end

        // Rising edge on bit 0, default timing: pulse at edge 4.
        wb_write(ADR_ENABLE, 32'h1, 4'hF);
        wb_write(ADR_EDGE_RISE, 32'h1, 4'hF);
        wb_write(ADR_DEBOUNCE, 32'h0, 4'hF);
        idle(1);
        sb.push_back('{32'h1, cyc + 4});
        event_in[0] = 1'b1;
        idle(6);
        rd_chk("t1_pending", ADR_PENDING, 32'h01);
        rd_chk("t1_level", ADR_LEVEL, 32'h01);
        wb_write(ADR_PENDING, 32'h1, 4'hF);
        rd_chk("t1_pending_clr", ADR_PENDING, 32'h00);

        // Debounce=3 on bit 1 with falling-edge detect.
        wb_write(ADR_DEBOUNCE, 32'h3, 4'hF);
        wb_write(ADR_EDGE_FALL, 32'h2, 4'hF);
        wb_write(ADR_ENABLE, 32'h2, 4'hF);
        event_in[1] = 1'b1;
        idle(10);
        rd_chk("t2_level_hi", ADR_LEVEL, 32'h03);
        event_in[1] = 1'b0;
        idle(3);
        event_in[1] = 1'b1;
        idle(10);
        rd_chk("t2_glitch_level", ADR_LEVEL, 32'h03);
        rd_chk("t2_glitch_pending", ADR_PENDING, 32'h00);
        sb.push_back('{32'h2, cyc + 7});
        event_in[1] = 1'b0;
        idle(12);
        rd_chk("t2_pending", ADR_PENDING, 32'h02);
        wb_write(ADR_PENDING, 32'h2, 4'hF);

        // Overflow on bit 0, then w1c colliding with a third hit.
        wb_write(ADR_DEBOUNCE, 32'h0, 4'hF);
        wb_write(ADR_ENABLE, 32'h1, 4'hF);
        repeat (2) begin
            event_in[0] = 1'b0;
            idle(6);
            sb.push_back('{32'h1, cyc + 4});
            event_in[0] = 1'b1;
            idle(6);
        end
        rd_chk("t3_overflow", ADR_OVERFLOW, 32'h01);
        rd_chk("t3_pending", ADR_PENDING, 32'h01);
        event_in[0] = 1'b0;
        idle(6);
        sb.push_back('{32'h1, cyc + 4});
        event_in[0] = 1'b1;
        idle(3);
        wb_write(ADR_PENDING, 32'h1, 4'hF);
        rd_chk("t3_set_wins", ADR_PENDING, 32'h01);
        wb_write(ADR_PENDING, 32'h1, 4'hF);
        rd_chk("t3_pending_w1c", ADR_PENDING, 32'h00);
        wb_write(ADR_OVERFLOW, 32'h1, 4'hF);
        rd_chk("t3_overflow_w1c", ADR_OVERFLOW, 32'h00);

        // Soft trigger ignores ENABLE; a write with no lanes selected does nothing.
        wb_write(ADR_ENABLE, 32'h0, 4'hF);
        sb.push_back('{32'h80, cyc + 2});
        wb_write(ADR_SOFT_TRIG, 32'h80, 4'hF);
        idle(2);
        rd_chk("t4_pending", ADR_PENDING, 32'h80);
        rd_chk("t4_soft_rd", ADR_SOFT_TRIG, 32'h0);
        wb_write(ADR_SOFT_TRIG, 32'h40, 4'h0);
        idle(3);
        rd_chk("t4_pending_nosel", ADR_PENDING, 32'h80);
        rd_chk("t4_overflow", ADR_OVERFLOW, 32'h00);

        // Byte lanes and unimplemented bits.
        wb_write(ADR_ENABLE, 32'hFFFF_FFFF, 4'b0001);
        rd_chk("t5_enable_lane0", ADR_ENABLE, 32'h0000_00FF);
        wb_write(ADR_ENABLE, 32'h0, 4'b0010);
        rd_chk("t5_enable_lane1", ADR_ENABLE, 32'h0000_00FF);
        wb_write(ADR_EDGE_RISE, 32'hFFFF_FF00, 4'hF);
        rd_chk("t5_rise_upper", ADR_EDGE_RISE, 32'h0);
        wb_write(ADR_DEBOUNCE, 32'h0000_01FF, 4'hF);
        rd_chk("t5_debounce", ADR_DEBOUNCE, 32'h0000_00FF);
        wb_write(ADR_DEBOUNCE, 32'h0, 4'hF);

        // Reset with PENDING=0xFF and a rising edge in flight on bit 2.
        wb_write(ADR_EDGE_RISE, 32'h4, 4'hF);
        sb.push_back('{32'hFF, cyc + 2});
        wb_write(ADR_SOFT_TRIG, 32'hFF, 4'hF);
        idle(2);
        rd_chk("t6_pending_ff", ADR_PENDING, 32'hFF);
        event_in[2] = 1'b1;
        idle(2);
        reset = 1'b1;
        idle(1);
        #1;
        chk("t6_rst_set_flg", set_flg, 32'd0);
        chk("t6_rst_dat_o", wb_if.s_wb_dat_o, 32'd0);
        rd_chk("t6_rst_pending", ADR_PENDING, 32'h0);
        reset = 1'b0;
        for (int a = 0; a < REG_NUM; a++) begin
            if (a != ADR_LEVEL) rd_chk($sformatf("t6_rd_%0d", a), a, 32'h0);
        end
        idle(10);
        rd_chk("t6_level", ADR_LEVEL, 32'h05);
        rd_chk("t6_pending_after", ADR_PENDING, 32'h0);

        idle(5);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/jelly2_rtos_event_capture.md
# jelly2_rtos_event_capture

Hardware event front-end for the jelly2_rtos event flag. Synchronises up to EVENT_NUM asynchronous external inputs, debounces them, and detects programmable edges. Records pending/overflow status in WISHBONE-accessible registers and emits one-cycle pulses on `set_flg`, which drives one flag group of the RTOS `ext_set_flg` input. It sits on the same peripheral WISHBONE bus as the RTOS core, decoded into its own address window.

## Interface
- `WB_ADR_WIDTH`, default 3: word address width (8 registers).
- `WB_DAT_WIDTH`, default 32: bus data width; must be ≥ EVENT_NUM.
- `WB_SEL_WIDTH`, default WB_DAT_WIDTH/8: byte-lane select width.
- `EVENT_NUM`, default 8: number of event inputs.
- `FLGPTN_WIDTH`, default 32: flag pattern width; must be ≥ EVENT_NUM.
- `SYNC_STAGES`, default 2: synchroniser depth; must be ≥ 2.
- `DEBOUNCE_WIDTH`, default 8: debounce count width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `event_in`  in  EVENT_NUM  asynchronous event lines.
- `set_flg`  out  FLGPTN_WIDTH  one-cycle flag-set pulses. Bit i maps to event i; bits ≥ EVENT_NUM are tied to 0.
- `s_wb_adr_i`  in  WB_ADR_WIDTH  register word address.
- `s_wb_dat_i`  in  WB_DAT_WIDTH  write data.
- `s_wb_dat_o`  out  WB_DAT_WIDTH  read data.
- `s_wb_we_i`  in  1  write enable.
- `s_wb_sel_i`  in  WB_SEL_WIDTH  byte-lane select.
- `s_wb_stb_i`  in  1  strobe.
- `s_wb_ack_o`  out  1  acknowledge; equals `s_wb_stb_i`.

## Operation
- Register map (word address, access, reset value):
  - 0 ENABLE, rw, 0.
  - 1 EDGE_RISE, rw, 0.
  - 2 EDGE_FALL, rw, 0.
  - 3 DEBOUNCE, rw, [DEBOUNCE_WIDTH-1:0], 0.
  - 4 PENDING, r / write-1-to-clear, 0.
  - 5 OVERFLOW, r / write-1-to-clear, 0.
  - 6 LEVEL, ro: filtered level.
  - 7 SOFT_TRIG, wo: reads return 0.
- Register bits above EVENT_NUM (or above DEBOUNCE_WIDTH for DEBOUNCE) read 0 and ignore writes.
- Writes honour `s_wb_sel_i` per byte lane, including w1c and SOFT_TRIG.
- Filter, per event:
  - SYNC_STAGES flip-flop chain feeds a debounce counter `cnt`.
  - If the synchronised value ≠ `level`: if `cnt == DEBOUNCE`, `level` takes the new value and `cnt` returns to 0; otherwise `cnt` increments.
  - If the synchronised value = `level`: `cnt` returns to 0.
- Detection, per event i, registered:
  - `hit = ENABLE[i] & ((rise & EDGE_RISE[i]) | (fall & EDGE_FALL[i]))`, where rise/fall come from the `level` transition.
  - `hit |= SOFT_TRIG write bit i`. Soft triggers ignore ENABLE and edge select.
- On hit:
  - `set_flg[i]` is high for exactly one cycle.
  - PENDING[i] is set.
  - If PENDING[i] was already 1, OVERFLOW[i] is set.
- Simultaneous hit and w1c on the same bit: the set wins; the bit stays 1. OVERFLOW follows the same rule.
- ENABLE cleared: filtering and LEVEL keep tracking; no pulses are produced, and PENDING is untouched.
- Reset values:
  - All outputs 0: `set_flg`, and `s_wb_dat_o` whenever there is no read strobe.
  - Sync chains, counters and `level` are 0.
  - After reset, an input held high produces a rising transition. It is suppressed because ENABLE is 0.

## Timing
- Count the first clock edge that samples a new `event_in` value as edge 1.
  - Sync output valid at edge SYNC_STAGES.
  - `level` updates at edge SYNC_STAGES+1+DEBOUNCE.
  - `set_flg` and PENDING are set at edge SYNC_STAGES+2+DEBOUNCE.
  - Default settings (SYNC_STAGES=2, DEBOUNCE=0): pulse at edge 4.
- Glitches shorter than DEBOUNCE+1 cycles at the sync output are rejected.
- A SOFT_TRIG write acked at edge k gives a `set_flg` pulse and PENDING set at edge k+1.
- WISHBONE access is single-cycle:
  - Ack is combinational with the strobe.
  - Read data is combinational from the registers.
  - Write effects are visible at the next edge.
- Reset asserted mid-operation clears everything at the next edge. A pulse in flight is lost.
- Back-to-back edges on one event (each after DEBOUNCE settles) give one pulse per edge.

## Structure
- Package `jelly2_rtos_event_capture_pkg` holds:
  - Register address localparams (ADR_ENABLE … ADR_SOFT_TRIG).
  - The access-type enum used by the bench.
- Sub-module `jelly2_rtos_event_capture_filter`, instantiated EVENT_NUM times in a generate loop:
  - Single-bit sync chain plus debounce.
  - Outputs `level` and one-cycle `rise`/`fall` strobes.
- Top module holds the registers, detection, pending/overflow logic and bus decode.

## Test plan
- ENABLE=0x01, EDGE_RISE=0x01, DEBOUNCE=0; drive `event_in[0]` 0→1 → `set_flg=0x1` for one cycle at edge 4; PENDING reads 0x01; LEVEL reads 0x01.
- DEBOUNCE=3, EDGE_FALL=0x02, ENABLE=0x02; bit 1 low for 3 cycles then high → no pulse. Bit 1 held low for 4 or more cycles → pulse at edge 2+2+3=7.
- Two rising edges on bit 0 without clearing → OVERFLOW=0x01. Write 0x01 to PENDING in the same cycle as a third hit → PENDING stays 0x01.
- Write SOFT_TRIG=0x80 with ENABLE=0 → `set_flg=0x80` one cycle later; PENDING=0x80.
- Write ENABLE=0xFFFFFFFF with `s_wb_sel_i=0b0001` → ENABLE reads 0x000000FF. Read address 7 → 0. `s_wb_ack_o` tracks `s_wb_stb_i` every cycle.
- Assert `reset` while PENDING=0xFF and an edge is in flight → all registers and `set_flg` are 0 at the next edge, and no pulse follows.
